// File: rtl/snoop_pkg.sv
// Shared encodings for the MSI snooping pair, plus the emitter's next-state function.
// Pure combinational definitions; no latency and no flow control.
package snoop_pkg;

  typedef enum logic [1:0] {
    ST_INVALID  = 2'd0,
    ST_SHARED   = 2'd1,
    ST_MODIFIED = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MSG_NONE       = 2'd0,
    MSG_READ_MISS  = 2'd1,
    MSG_WRITE_MISS = 2'd2,
    MSG_INVALIDATE = 2'd3
  } msg_e;

  typedef enum logic [1:0] {
    OP_RM = 2'd0,
    OP_RH = 2'd1,
    OP_WM = 2'd2,
    OP_WH = 2'd3
  } op_e;

  localparam logic ACTION_NONE      = 1'b0;
  localparam logic ACTION_WRITEBACK = 1'b1;
  localparam logic SIGNAL_NONE      = 1'b0;
  localparam logic SIGNAL_ABORT     = 1'b1;

  typedef struct packed {
    state_e state;
    msg_e   msg;
    logic   action;
  } tx_result_t;

  // Local-cache reaction to a processor operation; ST_ILLEGAL behaves as ST_INVALID.
  function automatic tx_result_t emit_next(input state_e cur, input op_e op);
    tx_result_t r;
    r.state  = cur;
    r.msg    = MSG_NONE;
    r.action = ACTION_NONE;
    case (cur)
      ST_SHARED: begin
        case (op)
          OP_RM: begin r.state = ST_SHARED;   r.msg = MSG_READ_MISS;  end
          OP_RH: begin r.state = ST_SHARED;   r.msg = MSG_NONE;       end
          OP_WM: begin r.state = ST_MODIFIED; r.msg = MSG_WRITE_MISS; end
          OP_WH: begin r.state = ST_MODIFIED; r.msg = MSG_INVALIDATE; end
          default: ;
        endcase
      end
      ST_MODIFIED: begin
        case (op)
          OP_RM: begin
            r.state  = ST_SHARED;
            r.msg    = MSG_READ_MISS;
            r.action = ACTION_WRITEBACK;
          end
          OP_WM: begin
            r.state  = ST_MODIFIED;
            r.msg    = MSG_WRITE_MISS;
            r.action = ACTION_WRITEBACK;
          end
          default: r.state = ST_MODIFIED;
        endcase
      end
      default: begin
        case (op)
          OP_RM: begin r.state = ST_SHARED;   r.msg = MSG_READ_MISS;  end
          OP_WM: begin r.state = ST_MODIFIED; r.msg = MSG_WRITE_MISS; end
          default: ;
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snoop_receptor_fsm.sv
// Remote-cache MSI FSM: applies one snooped bus message per bus_vld cycle, result registered next edge.
// No backpressure; a force load wins over a same-cycle message, which is then dropped.
module snoop_receptor_fsm
  import snoop_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_vld,
  input  logic [1:0] bus_msg,
  input  logic       force_vld,
  input  logic [1:0] force_state,
  output logic [1:0] rx_state,
  output logic       rx_signal
);

  state_e rx_state_q, rx_state_d;
  logic   rx_signal_q, rx_signal_d;
  msg_e   msg;

  assign msg = msg_e'(bus_msg);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_signal_d = rx_signal_q;
    if (force_vld) begin
      rx_state_d = state_e'(force_state);
    end else if (bus_vld) begin
      rx_signal_d = SIGNAL_NONE;
      case (rx_state_q)
        ST_SHARED: begin
          if (msg == MSG_WRITE_MISS || msg == MSG_INVALIDATE) rx_state_d = ST_INVALID;
        end
        ST_MODIFIED: begin
          // Dirty copy must be supplied on any miss; an invalidate cannot target a modified peer.
          case (msg)
            MSG_READ_MISS: begin
              rx_state_d  = ST_SHARED;
              rx_signal_d = SIGNAL_ABORT;
            end
            MSG_WRITE_MISS: begin
              rx_state_d  = ST_INVALID;
              rx_signal_d = SIGNAL_ABORT;
            end
            MSG_INVALIDATE: rx_state_d = ST_INVALID;
            default: ;
          endcase
        end
        default: rx_state_d = ST_INVALID;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= ST_SHARED;
      rx_signal_q <= SIGNAL_NONE;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_signal_q <= rx_signal_d;
    end
  end

  assign rx_state  = rx_state_q;
  assign rx_signal = rx_signal_q;

endmodule

// File: rtl/snooping_msi_pair.sv
// MSI pair for one block: local emitter FSM drives a one-cycle bus strobe into a snooping receptor.
// Tx outputs 1 edge after i_Start, Rx 2 edges; no backpressure, back-to-back starts accepted.
module snooping_msi_pair
  import snoop_pkg::*;
(
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Start,
  input  logic [1:0] i_Operation,
  input  logic       i_Force_Rx_Valid,
  input  logic [1:0] i_Force_Rx_State,
  output logic [1:0] o_Tx_State,
  output logic [1:0] o_Tx_Message,
  output logic       o_Tx_Action,
  output logic [1:0] o_Rx_State,
  output logic       o_Rx_Signal
);

  state_e     tx_state_q, tx_state_d;
  msg_e       tx_msg_q, tx_msg_d;
  logic       tx_action_q, tx_action_d;
  logic       bus_vld_q, bus_vld_d;
  tx_result_t nxt;

  assign nxt = emit_next(tx_state_q, op_e'(i_Operation));

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_msg_d    = tx_msg_q;
    tx_action_d = tx_action_q;
    bus_vld_d   = 1'b0;
    if (i_Start) begin
      tx_state_d  = nxt.state;
      tx_msg_d    = nxt.msg;
      tx_action_d = nxt.action;
      bus_vld_d   = (nxt.msg != MSG_NONE);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      tx_state_q  <= ST_INVALID;
      tx_msg_q    <= MSG_NONE;
      tx_action_q <= ACTION_NONE;
      bus_vld_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_msg_q    <= tx_msg_d;
      tx_action_q <= tx_action_d;
      bus_vld_q   <= bus_vld_d;
    end
  end

  // The held message register doubles as the bus payload during the strobe cycle.
  snoop_receptor_fsm u_receptor (
    .clk         (i_Clock),
    .rst_n       (i_Reset_n),
    .bus_vld     (bus_vld_q),
    .bus_msg     (tx_msg_q),
    .force_vld   (i_Force_Rx_Valid),
    .force_state (i_Force_Rx_State),
    .rx_state    (o_Rx_State),
    .rx_signal   (o_Rx_Signal)
  );

  assign o_Tx_State   = tx_state_q;
  assign o_Tx_Message = tx_msg_q;
  assign o_Tx_Action  = tx_action_q;

endmodule

// File: tb/tb_snooping_msi_pair.sv
// Directed self-checking bench for snooping_msi_pair; inputs change on negedge, outputs sampled on negedge.
module tb_snooping_msi_pair;

  logic       i_Clock = 1'b0;
  logic       i_Reset_n = 1'b0;
  logic       i_Start = 1'b0;
  logic [1:0] i_Operation = 2'd0;
  logic       i_Force_Rx_Valid = 1'b0;
  logic [1:0] i_Force_Rx_State = 2'd0;
  logic [1:0] o_Tx_State;
  logic [1:0] o_Tx_Message;
  logic       o_Tx_Action;
  logic [1:0] o_Rx_State;
  logic       o_Rx_Signal;

  int vectors = 0;
  int misses  = 0;

  localparam logic [1:0] RM = 2'd0, RH = 2'd1, WM = 2'd2, WH = 2'd3;

  always #5 i_Clock = ~i_Clock;

  snooping_msi_pair dut (
    .i_Clock          (i_Clock),
    .i_Reset_n        (i_Reset_n),
    .i_Start          (i_Start),
    .i_Operation      (i_Operation),
    .i_Force_Rx_Valid (i_Force_Rx_Valid),
    .i_Force_Rx_State (i_Force_Rx_State),
    .o_Tx_State       (o_Tx_State),
    .o_Tx_Message     (o_Tx_Message),
    .o_Tx_Action      (o_Tx_Action),
    .o_Rx_State       (o_Rx_State),
    .o_Rx_Signal      (o_Rx_Signal)
  );

  // One accepted op, then one more edge so the receptor has consumed its message.
  task automatic do_op(input logic [1:0] op);
    @(negedge i_Clock); i_Start = 1'b1; i_Operation = op;
    @(negedge i_Clock); i_Start = 1'b0;
    @(negedge i_Clock);
  endtask

  task automatic do_force(input logic [1:0] st);
    @(negedge i_Clock); i_Force_Rx_Valid = 1'b1; i_Force_Rx_State = st;
    @(negedge i_Clock); i_Force_Rx_Valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge i_Clock);
    vectors++;
    if ({o_Tx_State, o_Tx_Message, o_Tx_Action} !== {2'd0, 2'd0, 1'b0}) begin
      misses++; $display("FAIL reset_tx got st/msg/act=%0d/%0d/%0d exp 0/0/0", o_Tx_State, o_Tx_Message, o_Tx_Action);
    end
    vectors++;
    if ({o_Rx_State, o_Rx_Signal} !== {2'd1, 1'b0}) begin
      misses++; $display("FAIL reset_rx got st/sig=%0d/%0d exp 1/0", o_Rx_State, o_Rx_Signal);
    end
    i_Reset_n = 1'b1;
  endtask

  task automatic test_invalid_hits;
    do_op(RH);
    vectors++;
    if ({o_Tx_State, o_Tx_Message, o_Tx_Action, o_Rx_State, o_Rx_Signal} !== {2'd0, 2'd0, 1'b0, 2'd1, 1'b0}) begin
      misses++; $display("FAIL inv_rh got tx=%0d/%0d/%0d rx=%0d/%0d exp tx=0/0/0 rx=1/0", o_Tx_State, o_Tx_Message, o_Tx_Action, o_Rx_State, o_Rx_Signal);
    end
    do_op(WH);
    vectors++;
    if ({o_Tx_State, o_Tx_Message, o_Tx_Action, o_Rx_State, o_Rx_Signal} !== {2'd0, 2'd0, 1'b0, 2'd1, 1'b0}) begin
      misses++; $display("FAIL inv_wh got tx=%0d/%0d/%0d rx=%0d/%0d exp tx=0/0/0 rx=1/0", o_Tx_State, o_Tx_Message, o_Tx_Action, o_Rx_State, o_Rx_Signal);
    end
  endtask

  task automatic test_main_sequence;
    logic [1:0] ops  [4] = '{RM, WH, RM, WM};
    logic [4:0] etx  [4] = '{{2'd1, 2'd1, 1'b0}, {2'd2, 2'd3, 1'b0}, {2'd1, 2'd1, 1'b1}, {2'd2, 2'd2, 1'b0}};
    logic [2:0] erx  [4] = '{{2'd1, 1'b0}, {2'd0, 1'b0}, {2'd0, 1'b0}, {2'd0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i]);
      vectors++;
      if ({o_Tx_State, o_Tx_Message, o_Tx_Action} !== etx[i]) begin
        misses++; $display("FAIL main%0d_tx got %b exp %b", i, {o_Tx_State, o_Tx_Message, o_Tx_Action}, etx[i]);
      end
      vectors++;
      if ({o_Rx_State, o_Rx_Signal} !== erx[i]) begin
        misses++; $display("FAIL main%0d_rx got %b exp %b", i, {o_Rx_State, o_Rx_Signal}, erx[i]);
      end
    end
  endtask

  task automatic test_abort;
    do_force(2'd2);
    vectors++;
    if ({o_Rx_State, o_Rx_Signal} !== {2'd2, 1'b0}) begin
      misses++; $display("FAIL force_load got st/sig=%0d/%0d exp 2/0", o_Rx_State, o_Rx_Signal);
    end
    do_op(RM);
    vectors++;
    if ({o_Tx_State, o_Tx_Message, o_Tx_Action} !== {2'd1, 2'd1, 1'b1}) begin
      misses++; $display("FAIL abort_rm_tx got %0d/%0d/%0d exp 1/1/1", o_Tx_State, o_Tx_Message, o_Tx_Action);
    end
    vectors++;
    if ({o_Rx_State, o_Rx_Signal} !== {2'd1, 1'b1}) begin
      misses++; $display("FAIL abort_rm_rx got %0d/%0d exp 1/1", o_Rx_State, o_Rx_Signal);
    end
    do_force(2'd2);
    do_op(WM);
    vectors++;
    if ({o_Tx_State, o_Tx_Message, o_Tx_Action} !== {2'd2, 2'd2, 1'b0}) begin
      misses++; $display("FAIL abort_wm_tx got %0d/%0d/%0d exp 2/2/0", o_Tx_State, o_Tx_Message, o_Tx_Action);
    end
    vectors++;
    if ({o_Rx_State, o_Rx_Signal} !== {2'd0, 1'b1}) begin
      misses++; $display("FAIL abort_wm_rx got %0d/%0d exp 0/1", o_Rx_State, o_Rx_Signal);
    end
  endtask

  // Tx in MODIFIED, Rx INVALID/ABORT: WM strobe lands in the same cycle as a force to SHARED.
  task automatic test_force_priority;
    @(negedge i_Clock); i_Start = 1'b1; i_Operation = WM;
    @(negedge i_Clock); i_Start = 1'b0; i_Force_Rx_Valid = 1'b1; i_Force_Rx_State = 2'd1;
    @(negedge i_Clock); i_Force_Rx_Valid = 1'b0;
    vectors++;
    if ({o_Tx_State, o_Tx_Message, o_Tx_Action} !== {2'd2, 2'd2, 1'b1}) begin
      misses++; $display("FAIL prio_tx got %0d/%0d/%0d exp 2/2/1", o_Tx_State, o_Tx_Message, o_Tx_Action);
    end
    vectors++;
    if ({o_Rx_State, o_Rx_Signal} !== {2'd1, 1'b1}) begin
      misses++; $display("FAIL prio_rx got %0d/%0d exp 1/1", o_Rx_State, o_Rx_Signal);
    end
    @(negedge i_Clock);
    vectors++;
    if ({o_Rx_State, o_Rx_Signal} !== {2'd1, 1'b1}) begin
      misses++; $display("FAIL prio_drop got %0d/%0d exp 1/1", o_Rx_State, o_Rx_Signal);
    end
  endtask

  task automatic test_back_to_back;
    do_force(2'd2);
    @(negedge i_Clock); i_Start = 1'b1; i_Operation = RM;
    @(negedge i_Clock); i_Operation = WH;
    @(negedge i_Clock); i_Start = 1'b0;
    vectors++;
    if ({o_Rx_State, o_Rx_Signal} !== {2'd1, 1'b1}) begin
      misses++; $display("FAIL b2b_first_rx got %0d/%0d exp 1/1", o_Rx_State, o_Rx_Signal);
    end
    @(negedge i_Clock);
    vectors++;
    if ({o_Tx_State, o_Tx_Message, o_Tx_Action} !== {2'd2, 2'd3, 1'b0}) begin
      misses++; $display("FAIL b2b_tx got %0d/%0d/%0d exp 2/3/0", o_Tx_State, o_Tx_Message, o_Tx_Action);
    end
    vectors++;
    if ({o_Rx_State, o_Rx_Signal} !== {2'd0, 1'b0}) begin
      misses++; $display("FAIL b2b_second_rx got %0d/%0d exp 0/0", o_Rx_State, o_Rx_Signal);
    end
  endtask

  task automatic test_reset_mid;
    do_force(2'd2);
    @(negedge i_Clock); i_Start = 1'b1; i_Operation = RM;
    @(posedge i_Clock); #2 i_Reset_n = 1'b0; i_Start = 1'b0;
    #2 i_Reset_n = 1'b1;
    repeat (2) @(negedge i_Clock);
    vectors++;
    if ({o_Tx_State, o_Tx_Message, o_Tx_Action} !== {2'd0, 2'd0, 1'b0}) begin
      misses++; $display("FAIL midrst_tx got %0d/%0d/%0d exp 0/0/0", o_Tx_State, o_Tx_Message, o_Tx_Action);
    end
    vectors++;
    if ({o_Rx_State, o_Rx_Signal} !== {2'd1, 1'b0}) begin
      misses++; $display("FAIL midrst_rx got %0d/%0d exp 1/0", o_Rx_State, o_Rx_Signal);
    end
  endtask

  // Encoding 3 behaves as INVALID once a message arrives.
  task automatic test_illegal_state;
    do_force(2'd3);
    do_op(WM);
    vectors++;
    if ({o_Tx_State, o_Tx_Message, o_Tx_Action} !== {2'd2, 2'd2, 1'b0}) begin
      misses++; $display("FAIL illegal_tx got %0d/%0d/%0d exp 2/2/0", o_Tx_State, o_Tx_Message, o_Tx_Action);
    end
    vectors++;
    if ({o_Rx_State, o_Rx_Signal} !== {2'd0, 1'b0}) begin
      misses++; $display("FAIL illegal_rx got %0d/%0d exp 0/0", o_Rx_State, o_Rx_Signal);
    end
  endtask

  initial begin
    test_reset;
    test_invalid_hits;
    test_main_sequence;
    test_abort;
    test_force_priority;
    test_back_to_back;
    test_reset_mid;
    test_illegal_state;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
